// File: rtl/spi_flash_pkg.sv
// Shared opcodes, frame geometry and FSM encoding for the SPI flash responder.
package spi_flash_pkg;
  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_RDID = 8'h9F;
  localparam int FRAME_ADDR_W = 24;
  localparam int ADDR_BYTES   = FRAME_ADDR_W / 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_ID,
    ST_IGNORE
  } state_t;
endpackage

// File: rtl/spi_pin_sync.sv
// Synchronizes the raw SPI pins into wb_clk_i and detects sclk edges.
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic cs_n,
  input  logic sclk,
  input  logic mosi,
  output logic cs_n_s,
  output logic mosi_s,
  output logic sclk_rise,
  output logic sclk_fall
);
  logic [SYNC_STAGES-1:0] cs_q, sclk_q, mosi_q;
  logic                   sclk_prev;

  // cs_n idles deasserted so a reset never looks like a frame start
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cs_q      <= '1;
      sclk_q    <= '0;
      mosi_q    <= '0;
      sclk_prev <= 1'b0;
    end else begin
      cs_q      <= {cs_q[SYNC_STAGES-2:0], cs_n};
      sclk_q    <= {sclk_q[SYNC_STAGES-2:0], sclk};
      mosi_q    <= {mosi_q[SYNC_STAGES-2:0], mosi};
      sclk_prev <= sclk_q[SYNC_STAGES-1];
    end
  end

  assign cs_n_s    = cs_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_q[SYNC_STAGES-1];
  assign sclk_rise =  sclk_q[SYNC_STAGES-1] & ~sclk_prev;
  assign sclk_fall = ~sclk_q[SYNC_STAGES-1] &  sclk_prev;
endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash emulator: serves READ (0x03) from a preloadable byte array
// and RDID (0x9F) from a fixed JEDEC id, oversampling the pins on wb_clk_i.
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int          ADDR_W      = 10,
  parameter logic [23:0] JEDEC_ID    = 24'hEF4018,
  parameter int          SYNC_STAGES = 2
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              i_spi_cs_n,
  input  logic              i_spi_clk,
  input  logic              i_spi_mosi,
  output logic              o_spi_miso,
  output logic              o_spi_miso_oe,
  input  logic              i_mem_we,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [7:0]        i_mem_wdata,
  output logic              o_busy,
  output logic [7:0]        o_last_cmd
);
  localparam int DEPTH = 1 << ADDR_W;

  logic cs_n_s, mosi_s, sclk_rise, sclk_fall;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .cs_n     (i_spi_cs_n),
    .sclk     (i_spi_clk),
    .mosi     (i_spi_mosi),
    .cs_n_s   (cs_n_s),
    .mosi_s   (mosi_s),
    .sclk_rise(sclk_rise),
    .sclk_fall(sclk_fall)
  );

  state_t                  state;
  logic [2:0]              bit_cnt;
  logic [1:0]              byte_cnt;
  logic [FRAME_ADDR_W-1:0] shift_sr;
  logic [ADDR_W-1:0]       ptr, rd_addr;
  logic [7:0]              rdata, cmd_byte;
  logic                    rd_en, addr_last, byte_last;
  logic [7:0]              mem [DEPTH];

  assign cmd_byte  = {shift_sr[6:0], mosi_s};
  assign addr_last = (state == ST_ADDR) && sclk_rise && (bit_cnt == 3'd7) &&
                     (byte_cnt == 2'(ADDR_BYTES - 1));
  assign byte_last = (state == ST_DATA) && sclk_fall && (bit_cnt == 3'd7);
  assign rd_en     = !cs_n_s && (addr_last || byte_last);
  // upper address bits are dropped so reads alias across the 24-bit space
  assign rd_addr   = (state == ST_ADDR) ? {shift_sr[ADDR_W-2:0], mosi_s} : ptr + 1'b1;
  assign o_busy    = ~cs_n_s;

  // Read-first: a same-cycle preload to the fetched address yields the old byte.
  always_ff @(posedge wb_clk_i) begin
    if (i_mem_we) mem[i_mem_addr] <= i_mem_wdata;
    if (rd_en)    rdata <= mem[rd_addr];
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state         <= ST_IDLE;
      bit_cnt       <= '0;
      byte_cnt      <= '0;
      shift_sr      <= '0;
      ptr           <= '0;
      o_spi_miso    <= 1'b0;
      o_spi_miso_oe <= 1'b0;
      o_last_cmd    <= 8'h00;
    end else if (cs_n_s) begin
      state         <= ST_IDLE;
      bit_cnt       <= '0;
      byte_cnt      <= '0;
      o_spi_miso    <= 1'b0;
      o_spi_miso_oe <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: state <= ST_CMD;
        ST_CMD: if (sclk_rise) begin
          shift_sr <= {shift_sr[FRAME_ADDR_W-2:0], mosi_s};
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            o_last_cmd <= cmd_byte;
            byte_cnt   <= '0;
            if (cmd_byte == OP_READ) state <= ST_ADDR;
            else if (cmd_byte == OP_RDID) begin
              state    <= ST_ID;
              shift_sr <= JEDEC_ID;
            end else state <= ST_IGNORE;
          end
        end
        ST_ADDR: if (sclk_rise) begin
          shift_sr <= {shift_sr[FRAME_ADDR_W-2:0], mosi_s};
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) byte_cnt <= byte_cnt + 2'd1;
          if (addr_last) begin
            state <= ST_DATA;
            ptr   <= rd_addr;
          end
        end
        ST_DATA: if (sclk_fall) begin
          o_spi_miso_oe <= 1'b1;
          bit_cnt       <= bit_cnt + 3'd1;
          // bit 0 of each byte comes from the freshly fetched word
          if (bit_cnt == 3'd0) begin
            o_spi_miso                           <= rdata[7];
            shift_sr[FRAME_ADDR_W-1-:8]          <= {rdata[6:0], 1'b0};
          end else begin
            o_spi_miso <= shift_sr[FRAME_ADDR_W-1];
            shift_sr   <= {shift_sr[FRAME_ADDR_W-2:0], 1'b0};
          end
          if (bit_cnt == 3'd7) ptr <= ptr + 1'b1;
        end
        // zero fill after the id drains gives the trailing 0x00 bytes
        ST_ID: if (sclk_fall) begin
          o_spi_miso_oe <= 1'b1;
          o_spi_miso    <= shift_sr[FRAME_ADDR_W-1];
          shift_sr      <= {shift_sr[FRAME_ADDR_W-2:0], 1'b0};
        end
        ST_IGNORE: ;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: doc/spi_flash_responder.md
Name: spi_flash_responder

Overview:
- Synthesizable SPI-flash emulator: the target-side counterpart of wb_spi_flash_ctrl, so the controller can be exercised in simulation or on FPGA without a real flash part.
- Oversamples the SPI pins on the system clock and decodes SPI mode 0 READ (0x03) and RDID (0x9F).
- Serves data from an internal byte array that is preloaded through a simple write port.
- Sits on the board-model side of o_spi_cs_n / o_spi_clk / o_spi_mosi / i_spi_miso.

Parameters:
- ADDR_W, 10: byte-address width of the internal array; DEPTH = 2**ADDR_W.
- JEDEC_ID, 24'hEF4018: RDID response, MSB byte first.
- SYNC_STAGES, 2: synchronizer depth on cs_n, sclk and mosi; legal range 2..3.

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- i_spi_cs_n  in  1  chip select, active-low.
- i_spi_clk  in  1  SPI clock, mode 0 (idle low).
- i_spi_mosi  in  1  controller-to-target data.
- o_spi_miso  out  1  target-to-controller data.
- o_spi_miso_oe  out  1  MISO drive enable; 1 only in DATA or RDID output phases.
- i_mem_we  in  1  preload write strobe.
- i_mem_addr  in  ADDR_W  preload byte address.
- i_mem_wdata  in  8  preload byte.
- o_busy  out  1  synchronized CS asserted.
- o_last_cmd  out  8  most recently decoded opcode.

Behaviour:
- Clock and reset: one clock, wb_clk_i. Reset wb_rst_i is asynchronous and active-high.
- Reset values: o_spi_miso=0, o_spi_miso_oe=0, o_busy=0, o_last_cmd=8'h00, FSM=IDLE, bit and byte counters=0. The memory array is not reset.
- Input synchronizers:
  - cs_n synchronizer resets to 1; sclk and mosi synchronizers reset to 0.
  - Rising and falling sclk edges are detected from the last two synchronized samples.
  - Constraint: f(sclk) <= f(wb_clk_i)/8.
- CS handling:
  - Synchronized cs_n high forces IDLE every cycle, from any state. This aborts mid-byte, oe=0.
  - If a CS rise and an sclk edge appear in the same cycle, CS wins and the edge is ignored.
- Sampling and shifting:
  - MOSI is sampled on the detected sclk rise, MSB first, into an 8-bit shift register. A 3-bit counter wraps 7->0 at each byte boundary.
  - MISO changes only on the detected sclk fall, so it updates at most SYNC_STAGES+2 clocks after the pin edge.
- FSM states: IDLE, CMD, ADDR, DATA, ID, IGNORE.
  - IDLE -> CMD when cs_n is seen low.
  - CMD, after the 8th rise:
    - opcode latched into o_last_cmd.
    - 0x03 -> ADDR.
    - 0x9F -> ID.
    - any other opcode -> IGNORE.
  - ADDR: shifts 24 bits MSB first; the low ADDR_W bits form the read pointer, upper bits are discarded (aliasing). On the 32nd rise the array is read (registered, 1-cycle latency) and the state moves to DATA.
  - DATA:
    - oe=1. Bit 7 of mem[ptr] is driven on the fall that follows the 32nd rise; subsequent falls shift it out MSB first.
    - After each 8th fall the pointer increments, wrapping DEPTH-1 -> 0, and the next byte is fetched. The next byte's bit 7 is presented on the following fall, so a continuous read has no gap.
    - Continues until CS rises.
  - ID:
    - oe=1. JEDEC_ID is shifted out MSB first, starting on the fall after the 8th command rise.
    - After 24 bits, MISO=0 and oe stays 1 until CS rises.
  - IGNORE: oe=0; all sclk edges are ignored until CS rises.
- Output enable: oe=0 in IDLE, CMD, ADDR and IGNORE. o_spi_miso=0 whenever oe=0.
- Preload port:
  - Write takes effect on the clock edge whenever i_mem_we=1, regardless of SPI state.
  - A same-cycle write and SPI fetch to the same address returns the old byte (read-first).
- o_busy = synchronized ~cs_n.

Decomposition:
- Shared package spi_flash_pkg:
  - opcode constants: OP_READ=8'h03, OP_RDID=8'h9F.
  - FSM state enum.
  - address width of the SPI frame (24).
- One natural sub-module, spi_pin_sync: the synchronizers plus sclk rise/fall edge detection, with reset values as above.
- The memory is inferred inside spi_flash_responder.

Test Plan:
- Preload mem[0..15] with bytes 0x00..0x0F. Controller issues READ, address 0x000000, for 8 bytes -> MISO yields 00 01 02 .. 07; oe rises on the fall after the 32nd rise; o_last_cmd=0x03.
- With ADDR_W=10, READ at address 0x0003FE for 4 bytes, with mem[0x3FE]=AA, mem[0x3FF]=BB, mem[0]=CC, mem[1]=DD -> AA BB CC DD (wrap to 0).
- RDID: send 0x9F then 32 clocks -> EF 40 18 00; o_last_cmd=0x9F.
- Opcode 0x05 followed by 16 clocks -> oe stays 0 and MISO stays 0 throughout. A following READ of address 0x000002 in a new CS frame returns mem[2].
- Abort: raise CS after 3 bits of the 2nd data byte -> oe=0 within SYNC_STAGES+1 clocks. The next READ at address 0x000000 starts cleanly and returns 00 01.
- Assert wb_rst_i asynchronously mid-DATA -> oe and MISO drop to 0 immediately without a clock edge; o_last_cmd=00. After release, a READ works and the array contents are intact.
